// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared ALU op, forwarding-select and EX control types for the ID/EX stage
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SLL = 3'b001, ALU_SLT = 3'b010, ALU_SLTU = 3'b011,
    ALU_XOR = 3'b100, ALU_SRL = 3'b101, ALU_OR = 3'b110, ALU_AND = 3'b111
  } alu_ctrl_e;
  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;
  typedef struct packed {
    alu_ctrl_e alu_ctrl;
    logic alu_src;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks MEM, WB or register-file data for one source index (ports: rs, rf_data, mem_*, wb_* in; data out)
module fwd_mux #(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int REG_AW = rv32i_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   data
);
  import rv32i_pkg::*;
  fwd_sel_e sel;
  always_comb begin
    sel = FWD_REG;
    if (wb_reg_write && wb_rd != '0 && wb_rd == rs) sel = FWD_WB;
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs) sel = FWD_MEM;
    data = sel == FWD_MEM ? mem_result : sel == FWD_WB ? wb_result : rf_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with load-use bubbles, EX forwarding and a saturating bubble counter
// Ports: clk, rst_n (sync, active-low); id_* decode fields, flush; mem_*/wb_* forwarding sources;
// outputs stall_if_id, ex_valid, ALUop1/ALUop2/ALUControl, ex_rd, ex_* control, ex_store_data, ex_pc, bubble_count.
// Build option RV_ID_EX_FORWARD_EN: defined = forwarding muxes; undefined = no forwarding, stall on any RAW hazard.
module id_ex_stage #(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int REG_AW = rv32i_pkg::REG_AW,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              flush,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ALUop1,
  output logic [XLEN-1:0]   ALUop2,
  output logic [2:0]        ALUControl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CNT_W-1:0]  bubble_count
);
  import rv32i_pkg::*;
  ex_ctrl_t ctrl_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, op1, op2;
  logic lu, hz;
  function automatic logic dep(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                               input logic [REG_AW-1:0] rs2);
    return rd != '0 && (rd == rs1 || rd == rs2);
  endfunction
  assign lu = ex_valid & ctrl_q.mem_read & id_valid & dep(ex_rd, id_rs1, id_rs2);
`ifdef RV_ID_EX_FORWARD_EN
  logic [REG_AW-1:0] rs1_q, rs2_q;
  assign hz = lu;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      rs1_q <= id_rs1;
      rs2_q <= id_rs2;
    end
  end
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
    .rs(rs1_q), .rf_data(rd1_q), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_result(wb_result), .data(op1)
  );
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
    .rs(rs2_q), .rf_data(rd2_q), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_result(wb_result), .data(op2)
  );
`else
  // Without forwarding, any in-flight producer of a source register holds ID until it retires.
  logic unused_fwd;
  assign unused_fwd = ^{mem_result, wb_result};
  assign hz = lu | id_valid & ((ex_valid & ctrl_q.reg_write & dep(ex_rd, id_rs1, id_rs2)) |
                               (mem_reg_write & dep(mem_rd, id_rs1, id_rs2)) |
                               (wb_reg_write & dep(wb_rd, id_rs1, id_rs2)));
  assign op1 = rd1_q;
  assign op2 = rd2_q;
`endif
  assign stall_if_id = hz;
  assign ALUop1 = op1;
  assign ALUop2 = ctrl_q.alu_src ? imm_q : op2;
  assign ex_store_data = op2;
  assign ALUControl = ctrl_q.alu_ctrl;
  assign ex_reg_write = ex_valid & ctrl_q.reg_write;
  assign ex_mem_read = ex_valid & ctrl_q.mem_read;
  assign ex_mem_write = ex_valid & ctrl_q.mem_write;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
      ex_pc <= '0;
    end else begin
      rd1_q <= id_rd1;
      rd2_q <= id_rd2;
      imm_q <= id_imm;
      ex_pc <= id_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ctrl_q <= '0;
      ex_rd <= '0;
      bubble_count <= '0;
    end else if (flush || hz) begin
      ex_valid <= 1'b0;
      ctrl_q <= '0;
      ex_rd <= '0;
      // A flushed slot is not a hazard bubble, so only count when flush is absent.
      bubble_count <= bubble_count + CNT_W'(!flush && bubble_count != '1);
    end else begin
      ex_valid <= id_valid;
      ctrl_q <= '{alu_ctrl: alu_ctrl_e'(id_alu_ctrl), alu_src: id_alu_src,
                  reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write};
      ex_rd <= id_rd;
    end
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the RV32I 5-stage core, placed directly upstream of the ALU. It captures decode outputs and detects load-use hazards, inserting bubbles when needed. It applies EX-side operand forwarding from the EX/MEM and MEM/WB stages. Its outputs drive ALUop1, ALUop2 and ALUControl of the ALU, plus control bits passed on to EX/MEM.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register-address width
CNT_W, 16, width of the bubble performance counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rd1, id_rd2  in  XLEN  register-file read data for rs1, rs2
id_imm, id_pc  in  XLEN  sign-extended immediate; instruction PC
id_rs1, id_rs2, id_rd  in  REG_AW  source and destination register indices
id_alu_ctrl  in  3  func3-style ALU op (000 add … 111 and)
id_alu_src  in  1  1 = ALUop2 takes the immediate
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
flush  in  1  taken branch/jump; kill the instruction entering EX
mem_rd  in  REG_AW; mem_reg_write  in  1; mem_result  in  XLEN  EX/MEM forwarding source
wb_rd  in  REG_AW; wb_reg_write  in  1; wb_result  in  XLEN  MEM/WB forwarding source
stall_if_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX slot valid
ALUop1, ALUop2  out  XLEN  ALU operands
ALUControl  out  3  ALU operation
ex_rd  out  REG_AW; ex_reg_write, ex_mem_read, ex_mem_write  out  1  to EX/MEM
ex_store_data, ex_pc  out  XLEN  forwarded rs2 for stores; PC
bubble_count  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_n=0 at a rising edge): all stage registers go to 0, including ex_valid and bubble_count. After reset, all outputs read 0 and stall_if_id=0 until new instructions are captured.
- The stage register updates every cycle. There is no hold state: this stage is never stalled from downstream.
- Load-use hazard (lu), combinational:
  - lu = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - stall_if_id = lu.
- Next-state priority, highest first:
  - flush: capture a bubble (valid=0, all control bits 0).
  - lu: capture a bubble and increment bubble_count, saturating at all-ones.
  - otherwise: capture all id_* fields, with valid=id_valid.
- When flush and lu coincide: bubble captured, stall_if_id still asserted, bubble_count not incremented.
- Control outputs ex_reg_write, ex_mem_read and ex_mem_write are gated by ex_valid, so they are never 1 while ex_valid=0.
- Forwarding for each source s in {rs1, rs2}, evaluated combinationally on the registered indices:
  - MEM: mem_reg_write & mem_rd!=0 & mem_rd==s.
  - WB: wb_reg_write & wb_rd!=0 & wb_rd==s.
  - MEM wins over WB; otherwise the registered register-file data is used.
  - x0 is never forwarded.
- Operand selection:
  - ALUop1 = fwd(rs1).
  - ALUop2 = alu_src ? imm : fwd(rs2).
  - ex_store_data = fwd(rs2), regardless of alu_src.
- Latency: one cycle from ID inputs to EX outputs. Operands become valid in the same cycle as the forwarding sources.
- A reset asserted mid-stall clears everything. No pending stall survives reset.

Optional Feature:
RV_ID_EX_FORWARD_EN.
- Defined: forwarding as described above.
- Undefined:
  - Operands come directly from the registered read data; no forwarding paths.
  - stall_if_id is additionally asserted for any RAW hazard against a valid EX instruction with ex_reg_write, or against mem_reg_write/mem_rd, or against wb_reg_write/wb_rd (rd!=0).
  - Each stalled cycle captures a bubble and counts in bubble_count.

Decomposition:
- Package rv32i_pkg:
  - alu_ctrl_e enum (ALU_ADD=3'b000 … ALU_AND=3'b111).
  - fwd_sel_e (FWD_REG, FWD_MEM, FWD_WB).
  - ex_ctrl_t packed struct (alu_ctrl, alu_src, reg_write, mem_read, mem_write).
  - XLEN and REG_AW constants.
- One sub-module, fwd_mux: takes the index, the registered data, and the MEM/WB sources, and returns the selected data. It is instantiated twice.

Test Plan:
- Plain capture: id_valid=1, rd1=5, imm=7, alu_src=1, alu_ctrl=000 -> next cycle ALUop1=5, ALUop2=7, ALUControl=000, ex_valid=1.
- Forward priority: EX rs1=3, mem_rd=3 with mem_result=0xAA, wb_rd=3 with wb_result=0xBB -> ALUop1=0xAA. Drop the mem match -> ALUop1=0xBB. rs1=0 with both matching -> ALUop1 = registered data.
- Load-use: EX holds lw x4 (mem_read=1); ID has add using rs2=x4 -> stall_if_id=1 for one cycle, next ex_valid=0, bubble_count=1. Cycle after, add enters with stall_if_id=0.
- Flush + lu in the same cycle -> bubble captured, bubble_count unchanged, ex_reg_write=0.
- Reset mid-operation: rst_n=0 for one edge while ex_valid=1 -> all outputs 0, bubble_count=0.
- Store data: alu_src=1, rs2 forwarded from WB = 0x1234 -> ALUop2=imm, ex_store_data=0x1234.
